// File: rtl/ascon_hash_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the Ascon hash/XOF sequencer.
package ascon_hash_ctrl_pkg;
   localparam logic [63:0] HASH_IV      = 64'h0000080100CC0002;
   localparam logic [63:0] XOF_IV       = 64'h0000080000CC0003;
   localparam logic [1:0]  MODE_HASH    = 2'b01;
   localparam logic [1:0]  MODE_XOF     = 2'b10;
   localparam logic [2:0]  TUSER_MSG    = 3'd1;
   localparam logic [2:0]  TUSER_DIGEST = 3'd2;
   localparam int          HASH_LEN     = 32;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_WR, S_PERM, S_PWAIT, S_ABSORB,
      S_PAD, S_SQZ_LOAD, S_SQZ_OUT, S_DONE
   } hash_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] k);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
      return c;
   endfunction

   // n in 0..8 -> n low bits set
   function automatic logic [7:0] keep_mask(input logic [3:0] n);
      return 8'hFF >> (4'd8 - n);
   endfunction
endpackage

// File: rtl/ascon_hash_ctrl_if.sv
// AXI-stream bundle used for both the message input and the digest output.
interface ascon_hash_ctrl_if #(
   parameter int DW = 64,
   parameter int UW = 3
);
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic [UW-1:0]   tuser;
   logic            tlast;
   logic            tvalid;
   logic            tready;

   modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/ascon_hash_ctrl_pad64.sv
// 10* padding of one 64-bit rate word; flags a full last word that needs a separate pad block.
module ascon_hash_ctrl_pad64 (
   input  logic [63:0] tdata,
   input  logic [3:0]  n,
   input  logic        last,
   output logic [63:0] padded,
   output logic        extra
);
   logic [6:0]  sh;
   logic [63:0] mask;

   always_comb begin
      sh     = {n, 3'b000};
      mask   = ~(64'hFFFF_FFFF_FFFF_FFFF << sh);
      padded = tdata;
      if (last && n < 4'd8) padded = (tdata & mask) | (64'h1 << sh);
      extra  = last && (n == 4'd8);
   end
endmodule

// File: rtl/ascon_hash_ctrl.sv
// Sequencer driving ascon_core through IV load, padded absorb, p[12] and digest squeeze.
module ascon_hash_ctrl
   import ascon_hash_ctrl_pkg::*;
#(
   parameter int XOF_LEN_W = 32,
   parameter int TDATA_W   = 64,
   parameter int TUSER_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode_i,
   input  logic                 start_i,
   input  logic [XOF_LEN_W-1:0] xof_len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   input  logic                 ascon_ready_i,
   output logic                 start_perm_o,
   output logic                 round_config_o,
   output logic [2:0]           word_sel_o,
   output logic [TDATA_W-1:0]   data_o,
   output logic                 write_en_o,
   input  logic [TDATA_W-1:0]   core_data_i,
   ascon_hash_ctrl_if.slave     s_axis,
   ascon_hash_ctrl_if.master    m_axis
);
   hash_state_t          state_q, state_d, ret_q, ret_d;
   logic [2:0]           wcnt_q;
   logic                 pw_skip_q, is_xof_q, err_q;
   logic [XOF_LEN_W-1:0] rem_q;
   logic [TDATA_W-1:0]   out_data_q;
   logic [7:0]           out_keep_q;
   logic [TUSER_W-1:0]   out_user_q;
   logic                 out_last_q, out_valid_q;
   logic [3:0]           beat_n;
   logic [63:0]          padded;
   logic                 needs_pad, s_hs, m_hs, mode_ok, len_zero, start_ok;

   assign beat_n   = popcount8(s_axis.tkeep);
   assign s_hs     = (state_q == S_ABSORB) && s_axis.tvalid;
   assign m_hs     = (state_q == S_SQZ_OUT) && out_valid_q && m_axis.tready;
   assign mode_ok  = (mode_i == MODE_HASH) || (mode_i == MODE_XOF);
   assign start_ok = (state_q == S_IDLE) && start_i && mode_ok;
   assign len_zero = (rem_q == '0);

   ascon_hash_ctrl_pad64 u_pad (
      .tdata  (s_axis.tdata),
      .n      (beat_n),
      .last   (s_axis.tlast),
      .padded (padded),
      .extra  (needs_pad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ret_q   <= S_ABSORB;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      case (state_q)
         S_IDLE:    if (start_ok) state_d = S_INIT_WR;
         S_INIT_WR: if (wcnt_q == 3'd4) begin
            state_d = S_PERM;
            ret_d   = S_ABSORB;
         end
         S_PERM:    if (ascon_ready_i) state_d = S_PWAIT;
         // the core may not have dropped ready yet on the first wait cycle
         S_PWAIT:   if (!pw_skip_q && ascon_ready_i) state_d = ret_q;
         S_ABSORB:  if (s_axis.tvalid) begin
            state_d = S_PERM;
            if (!s_axis.tlast)          ret_d   = S_ABSORB;
            else if (needs_pad)         ret_d   = S_PAD;
            else if (is_xof_q && len_zero) state_d = S_DONE;
            else                        ret_d   = S_SQZ_LOAD;
         end
         S_PAD: begin
            state_d = (is_xof_q && len_zero) ? S_DONE : S_PERM;
            ret_d   = S_SQZ_LOAD;
         end
         S_SQZ_LOAD: state_d = S_SQZ_OUT;
         S_SQZ_OUT:  if (m_hs) begin
            state_d = out_last_q ? S_DONE : S_PERM;
            ret_d   = S_SQZ_LOAD;
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o        = (state_q != S_IDLE);
      done_o        = (state_q == S_DONE);
      start_perm_o  = (state_q == S_PERM) && ascon_ready_i;
      write_en_o    = 1'b0;
      word_sel_o    = 3'd0;
      data_o        = '0;
      s_axis.tready = 1'b0;
      case (state_q)
         S_INIT_WR: begin
            write_en_o = 1'b1;
            word_sel_o = wcnt_q;
            if (wcnt_q == 3'd0) data_o = is_xof_q ? XOF_IV : HASH_IV;
         end
         S_ABSORB: begin
            s_axis.tready = 1'b1;
            write_en_o    = s_axis.tvalid;
            if (s_axis.tvalid) data_o = core_data_i ^ padded;
         end
         S_PAD: begin
            write_en_o = 1'b1;
            data_o     = core_data_i ^ 64'h1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q      <= '0;
         pw_skip_q   <= 1'b0;
         is_xof_q    <= 1'b0;
         err_q       <= 1'b0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_user_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wcnt_q    <= (state_q == S_INIT_WR) ? wcnt_q + 3'd1 : 3'd0;
         pw_skip_q <= start_perm_o;
         err_q     <= ((state_q == S_IDLE) && start_i && !mode_ok) ||
                      (s_hs && (s_axis.tuser != TUSER_MSG));
         if (start_ok) begin
            is_xof_q <= (mode_i == MODE_XOF);
            rem_q    <= (mode_i == MODE_XOF) ? xof_len_i : XOF_LEN_W'(HASH_LEN);
         end
         if (state_q == S_SQZ_LOAD) begin
            out_data_q  <= core_data_i;
            out_keep_q  <= (rem_q >= XOF_LEN_W'(8)) ? 8'hFF : keep_mask(rem_q[3:0]);
            out_last_q  <= (rem_q <= XOF_LEN_W'(8));
            out_user_q  <= TUSER_DIGEST;
            out_valid_q <= 1'b1;
         end else if (m_hs) begin
            out_valid_q <= 1'b0;
            rem_q       <= (rem_q > XOF_LEN_W'(8)) ? rem_q - XOF_LEN_W'(8) : '0;
         end
      end
   end

   assign err_o          = err_q;
   assign round_config_o = 1'b1;
   assign m_axis.tdata   = out_data_q;
   assign m_axis.tkeep   = out_keep_q;
   assign m_axis.tuser   = out_user_q;
   assign m_axis.tlast   = out_last_q;
   assign m_axis.tvalid  = out_valid_q;
endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench: behavioural ascon_core with real p[12], byte-level reference hash feeding a beat scoreboard.
module tb_ascon_hash_ctrl;
   localparam logic [63:0] HASH_IV = 64'h0000080100CC0002;
   localparam logic [63:0] XOF_IV  = 64'h0000080000CC0003;
   localparam logic [2:0]  U_MSG = 3'd1, U_DIG = 3'd2;
   localparam int LAT = 3;

   typedef logic [4:0][63:0] st_t;
   typedef logic [7:0] bq_t[$];
   typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last; logic [2:0] user;} beat_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] mode_i = '0;
   logic start_i = 1'b0;
   logic [31:0] xof_len_i = '0;
   logic busy_o, done_o, err_o, ascon_ready_i, start_perm_o, round_config_o, write_en_o;
   logic [2:0] word_sel_o;
   logic [63:0] data_o, core_data_i;

   ascon_hash_ctrl_if #(.DW(64), .UW(3)) s_if();
   ascon_hash_ctrl_if #(.DW(64), .UW(3)) m_if();

   ascon_hash_ctrl #(.XOF_LEN_W(32), .TDATA_W(64), .TUSER_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .start_i(start_i), .xof_len_i(xof_len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .ascon_ready_i(ascon_ready_i),
      .start_perm_o(start_perm_o), .round_config_o(round_config_o), .word_sel_o(word_sel_o),
      .data_o(data_o), .write_en_o(write_en_o), .core_data_i(core_data_i),
      .s_axis(s_if.slave), .m_axis(m_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int done_cnt = 0, err_cnt = 0, perm_cnt = 0;
   beat_t exp_q[$], got_q[$];

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic st_t p12(input st_t si);
      st_t s;
      logic [63:0] t0, t1, t2, t3, t4;
      s = si;
      for (int r = 0; r < 12; r++) begin
         s[2] ^= 64'(240 - 15 * r);
         s[0] ^= s[4]; s[4] ^= s[3]; s[2] ^= s[1];
         t0 = ~s[0] & s[1]; t1 = ~s[1] & s[2]; t2 = ~s[2] & s[3];
         t3 = ~s[3] & s[4]; t4 = ~s[4] & s[0];
         s[0] ^= t1; s[1] ^= t2; s[2] ^= t3; s[3] ^= t4; s[4] ^= t0;
         s[1] ^= s[0]; s[0] ^= s[4]; s[3] ^= s[2]; s[2] = ~s[2];
         s[0] ^= ror(s[0], 19) ^ ror(s[0], 28);
         s[1] ^= ror(s[1], 61) ^ ror(s[1], 39);
         s[2] ^= ror(s[2], 1)  ^ ror(s[2], 6);
         s[3] ^= ror(s[3], 10) ^ ror(s[3], 17);
         s[4] ^= ror(s[4], 7)  ^ ror(s[4], 41);
      end
      return s;
   endfunction

   // core model: writes land on the edge, permutation result appears after LAT busy cycles
   st_t st = '0;
   int busy_cnt = 0;
   assign ascon_ready_i = (busy_cnt == 0);
   assign core_data_i   = (word_sel_o < 3'd5) ? st[word_sel_o] : 64'h0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_cnt <= 0;
      else begin
         if (write_en_o) st[word_sel_o] <= data_o;
         if (start_perm_o) begin
            busy_cnt <= LAT;
            perm_cnt <= perm_cnt + 1;
         end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            st <= p12(st);
         end else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (done_o) done_cnt <= done_cnt + 1;
      if (err_o)  err_cnt  <= err_cnt + 1;
   end

   task automatic model_push(input logic [1:0] mode, input bq_t msg, input int len);
      st_t s;
      logic [63:0] w;
      beat_t b;
      int nb, i, r, outlen;
      s = '0;
      s[0] = (mode == 2'b01) ? HASH_IV : XOF_IV;
      s = p12(s);
      outlen = (mode == 2'b01) ? 32 : len;
      nb = msg.size();
      i = 0;
      while (nb - i >= 8) begin
         for (int k = 0; k < 8; k++) w[8*k +: 8] = msg[i+k];
         s[0] ^= w; s = p12(s); i += 8;
      end
      w = '0; r = nb - i;
      for (int k = 0; k < r; k++) w[8*k +: 8] = msg[i+k];
      w[8*r +: 8] = 8'h01;
      s[0] ^= w; s = p12(s);
      for (int o = 0; o < outlen; o += 8) begin
         r = outlen - o;
         b.data = s[0];
         b.keep = (r >= 8) ? 8'hFF : (8'hFF >> (8 - r));
         b.last = (r <= 8);
         b.user = U_DIG;
         exp_q.push_back(b);
         if (!b.last) s = p12(s);
      end
   endtask

   task automatic run_op(input logic [1:0] mode, input bq_t msg, input int len, input bit bad_user,
                         input bit bp, output int n_done, output int n_perm, output int n_unst,
                         output bit tmo);
      int d0, p0;
      exp_q.delete(); got_q.delete();
      model_push(mode, msg, len);
      tmo = 0; n_perm = -1; n_unst = 0;
      d0 = done_cnt; p0 = perm_cnt;
      @(negedge clk); mode_i = mode; xof_len_i = len; start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      fork
         begin : drv
            int nb, beats, n, w;
            nb = msg.size();
            beats = (nb == 0) ? 1 : (nb + 7) / 8;
            for (int b = 0; b < beats; b++) begin
               n = (nb - 8*b >= 8) ? 8 : nb - 8*b;
               for (int k = 0; k < 8; k++) s_if.tdata[8*k +: 8] = (k < n) ? msg[8*b+k] : 8'hA5;
               s_if.tkeep  = 8'hFF >> (8 - n);
               s_if.tlast  = (b == beats - 1);
               s_if.tuser  = bad_user ? 3'd5 : U_MSG;
               s_if.tvalid = 1'b1;
               w = 0;
               while (!s_if.tready && w < 2000) begin @(negedge clk); w++; end
               if (w >= 2000) begin tmo = 1; break; end
               @(negedge clk);
            end
            s_if.tvalid = 1'b0;
         end
         begin : col
            int hold, cyc;
            bit seen;
            beat_t cur, ref_b;
            hold = 0; cyc = 0; seen = 0;
            while (!seen && cyc < 5000) begin
               @(negedge clk); cyc++;
               if (done_o) seen = 1;
               if (m_if.tvalid) begin
                  cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
                  if (hold == 0) ref_b = cur;
                  else if (cur !== ref_b) n_unst++;
                  if (bp && hold < 5) begin m_if.tready = 1'b0; hold++; end
                  else begin
                     m_if.tready = 1'b1;
                     got_q.push_back(cur);
                     if (n_perm < 0) n_perm = perm_cnt - p0;
                     hold = 0;
                  end
               end else m_if.tready = 1'b0;
            end
            m_if.tready = 1'b0;
            if (!seen) tmo = 1;
         end
      join
      repeat (3) @(negedge clk);
      n_done = done_cnt - d0;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({busy_o, done_o, err_o, start_perm_o, write_en_o, word_sel_o, data_o, s_if.tready,
           m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== '0) begin
         errors++; $display("FAIL reset_outputs busy=%b done=%b err=%b wr=%b data=%h mvalid=%b: all 0 required",
                            busy_o, done_o, err_o, write_en_o, data_o, m_if.tvalid);
      end
      checks++;
      if (round_config_o !== 1'b1) begin errors++; $display("FAIL reset_round_config got=%b exp=1", round_config_o); end
   endtask

   task automatic test_hash_empty;
      bq_t m; int nd, np, nu; bit tmo; beat_t g, e;
      m = {};
      run_op(2'b01, m, 0, 0, 0, nd, np, nu, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL hash_empty_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL hash_empty_beats got=%0d exp=4", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL hash_empty_beat got=%h exp=%h", g, e); end
      end
      checks++; if (nd != 1) begin errors++; $display("FAIL hash_empty_done got=%0d exp=1", nd); end
   endtask

   task automatic test_hash_full_block;
      bq_t m; int nd, np, nu; bit tmo; beat_t g, e;
      m = {};
      for (int i = 0; i < 8; i++) m.push_back(8'(i));
      run_op(2'b01, m, 0, 0, 0, nd, np, nu, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL hash8_timeout got=1 exp=0"); end
      checks++; if (np != 3) begin errors++; $display("FAIL hash8_perms_before_first got=%0d exp=3", np); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL hash8_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL hash8_beat got=%h exp=%h", g, e); end
      end
      checks++; if (nd != 1) begin errors++; $display("FAIL hash8_done got=%0d exp=1", nd); end
   endtask

   task automatic test_xof;
      bq_t m; int nd, np, nu; bit tmo; beat_t g, e;
      m = '{8'h61, 8'h62, 8'h63};
      run_op(2'b10, m, 13, 0, 0, nd, np, nu, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL xof13_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL xof13_beats got=%0d exp=2", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL xof13_beat got=%h exp=%h", g, e); end
      end
      run_op(2'b10, m, 0, 0, 0, nd, np, nu, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL xof0_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL xof0_beats got=%0d exp=0", got_q.size()); end
      checks++; if (nd != 1) begin errors++; $display("FAIL xof0_done got=%0d exp=1", nd); end
   endtask

   task automatic test_backpressure;
      bq_t m; int nd, np, nu; bit tmo; beat_t g, e;
      m = {};
      for (int i = 0; i < 11; i++) m.push_back(8'(8'h30 + i));
      run_op(2'b01, m, 0, 0, 1, nd, np, nu, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
      checks++; if (nu != 0) begin errors++; $display("FAIL bp_stable changes=%0d exp=0", nu); end
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_beats got=%0d exp=4", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL bp_beat got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_errors;
      bq_t m; int nd, np, nu, e0; bit tmo, busy_seen; beat_t g, e;
      e0 = err_cnt; busy_seen = 0;
      @(negedge clk); mode_i = 2'b11; start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      repeat (4) begin busy_seen |= busy_o; @(negedge clk); end
      checks++; if (busy_seen) begin errors++; $display("FAIL badmode_busy got=1 exp=0"); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL badmode_err pulses=%0d exp=1", err_cnt - e0); end
      m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      e0 = err_cnt;
      run_op(2'b01, m, 0, 1, 0, nd, np, nu, tmo);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL badtuser_err pulses=%0d exp=1", err_cnt - e0); end
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL badtuser_beats got=%0d exp=4", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL badtuser_beat got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_reset_mid_absorb;
      bq_t m; int nd, np, nu, w; bit tmo; beat_t g, e;
      @(negedge clk); mode_i = 2'b01; start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      s_if.tdata = 64'h0123_4567_89AB_CDEF; s_if.tkeep = 8'hFF; s_if.tlast = 1'b0;
      s_if.tuser = U_MSG; s_if.tvalid = 1'b1;
      w = 0;
      while (!s_if.tready && w < 200) begin @(negedge clk); w++; end
      @(negedge clk); s_if.tvalid = 1'b0;
      while (!s_if.tready && w < 400) begin @(negedge clk); w++; end
      checks++; if (w >= 400) begin errors++; $display("FAIL rstmid_reach_absorb waited=%0d limit=400", w); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, err_o, start_perm_o, write_en_o, word_sel_o, data_o, s_if.tready, m_if.tvalid} !== '0) begin
         errors++; $display("FAIL rstmid_outputs busy=%b tready=%b wr=%b data=%h: all 0 required",
                            busy_o, s_if.tready, write_en_o, data_o);
      end
      @(negedge clk); rst_n = 1'b1;
      m = {};
      for (int i = 0; i < 20; i++) m.push_back(8'(8'hC0 ^ i));
      run_op(2'b01, m, 0, 0, 0, nd, np, nu, tmo);
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rstmid_beats got=%0d exp=4", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL rstmid_beat got=%h exp=%h", g, e); end
      end
      checks++; if (nd != 1) begin errors++; $display("FAIL rstmid_done got=%0d exp=1", nd); end
   endtask

   initial begin
      s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
      m_if.tready = 1'b0;
      test_reset;
      @(negedge clk); rst_n = 1'b1;
      test_hash_empty;
      test_hash_full_block;
      test_xof;
      test_backpressure;
      test_errors;
      test_reset_mid_absorb;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
